// File: rtl/bram_multibank.sv
// Multi-bank simple dual-port block RAM with a pipelined read path and a
// whole-memory clear sweep that zeroes one address per cycle in every bank.
module bram_multibank #(
   parameter int unsigned DLEN     = 32,
   parameter int unsigned HLEN     = 9,
   parameter int unsigned NBANK    = 4,
   parameter int unsigned RLAT     = 1,
   parameter int unsigned RDW_MODE = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NBANK-1:0]       wen,
   input  logic [NBANK*HLEN-1:0]  waddr,
   input  logic [NBANK*DLEN-1:0]  din,
   input  logic [NBANK-1:0]       ren,
   input  logic [NBANK*HLEN-1:0]  raddr,
   output logic [NBANK*DLEN-1:0]  dout,
   output logic [NBANK-1:0]       dvalid,
   input  logic                   clr,
   output logic                   busy
);

   localparam int unsigned DEPTH = 2 ** HLEN;

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e          state_q, state_d;
   logic [HLEN-1:0] cnt_q, cnt_d;

   assign busy = (state_q == StClear);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (clr) begin
               state_d = StClear;
               cnt_d   = '0;
            end
         end
         StClear: begin
            // Counter parks on the last address instead of wrapping.
            if (cnt_q == {HLEN{1'b1}}) state_d = StIdle;
            else                       cnt_d   = cnt_q + 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      logic [DLEN-1:0] mem [DEPTH];
      logic [HLEN-1:0] wa, ra;
      logic [DLEN-1:0] wd, rd_word;
      logic            rd_acc;
      logic [DLEN-1:0] pipe_d [RLAT];
      logic [RLAT-1:0] pipe_v;
      logic [DLEN-1:0] dout_q;
      logic            dvalid_q;

      assign wa     = waddr[b*HLEN +: HLEN];
      assign ra     = raddr[b*HLEN +: HLEN];
      assign wd     = din[b*DLEN +: DLEN];
      assign rd_acc = ren[b] & ~busy;

      always_comb begin
         rd_word = mem[ra];
         if ((RDW_MODE != 0) && wen[b] && (wa == ra)) rd_word = wd;
      end

      // The sweep write on a reset edge still lands; only user writes are blocked.
      always_ff @(posedge clk) begin
         if (busy)                 mem[cnt_q] <= '0;
         else if (wen[b] && !reset) mem[wa]    <= wd;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            pipe_v   <= '0;
            for (int k = 0; k < RLAT; k++) pipe_d[k] <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
         end else begin
            pipe_v[0] <= rd_acc;
            if (rd_acc) pipe_d[0] <= rd_word;
            for (int k = 1; k < RLAT; k++) begin
               pipe_v[k] <= pipe_v[k-1];
               if (pipe_v[k-1]) pipe_d[k] <= pipe_d[k-1];
            end
            dvalid_q <= pipe_v[RLAT-1];
            if (pipe_v[RLAT-1]) dout_q <= pipe_d[RLAT-1];
         end
      end

      assign dout[b*DLEN +: DLEN] = dout_q;
      assign dvalid[b]            = dvalid_q;
   end

endmodule

// File: tb/tb_bram_multibank.sv
// Directed bench for bram_multibank (DLEN=32, HLEN=4, NBANK=2, RLAT=2); two
// instances differ only in read-during-write mode and share all inputs.
module tb_bram_multibank;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  wen, ren;
   logic [7:0]  waddr, raddr;
   logic [63:0] din;
   logic        clr;
   logic [63:0] dout0, dout1;
   logic [1:0]  dvalid0, dvalid1;
   logic        busy0, busy1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bram_multibank #(.DLEN(32), .HLEN(4), .NBANK(2), .RLAT(2), .RDW_MODE(0)) dut0 (
      .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .din(din), .ren(ren),
      .raddr(raddr), .dout(dout0), .dvalid(dvalid0), .clr(clr), .busy(busy0)
   );

   bram_multibank #(.DLEN(32), .HLEN(4), .NBANK(2), .RLAT(2), .RDW_MODE(1)) dut1 (
      .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .din(din), .ren(ren),
      .raddr(raddr), .dout(dout1), .dvalid(dvalid1), .clr(clr), .busy(busy1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_all();
      for (int i = 0; i < 16; i++) begin
         wen   = 2'b11;
         waddr = {4'(i), 4'(i)};
         din   = {32'hC000_0000 + 32'(i + 1), 32'hB000_0000 + 32'(i + 1)};
         step();
      end
      wen = 2'b00;
   endtask

   // Issue one read to both banks at address a; return what is seen two edges later.
   task automatic read_pair(input logic [3:0] a, output logic [63:0] d0,
                            output logic [63:0] d1, output logic [1:0] v);
      ren   = 2'b11;
      raddr = {a, a};
      step();
      ren = 2'b00;
      step();
      step();
      d0 = dout0;
      d1 = dout1;
      v  = dvalid0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (busy0 !== 1'b0 || dvalid0 !== 2'b00 || dout0 !== 64'h0) begin
         failures++;
         $display("FAIL reset_state: busy=%b dvalid=%b dout=%h, want 0 0 0", busy0, dvalid0, dout0);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      wen   = 2'b11;
      waddr = {4'd3, 4'd3};
      din   = {32'h1234_5678, 32'hA5A5_A5A5};
      step();
      wen   = 2'b00;
      ren   = 2'b11;
      raddr = {4'd3, 4'd3};
      step();
      ren = 2'b00;
      checks++;
      if (dvalid0 !== 2'b00) begin
         failures++;
         $display("FAIL basic_t0_valid: dvalid=%b want 00", dvalid0);
      end
      step();
      checks++;
      if (dvalid0 !== 2'b00) begin
         failures++;
         $display("FAIL basic_t1_valid: dvalid=%b want 00", dvalid0);
      end
      step();
      checks++;
      if (dvalid0 !== 2'b11 || dout0 !== 64'h1234_5678_A5A5_A5A5) begin
         failures++;
         $display("FAIL basic_t2_data: dvalid=%b dout=%h want 11 12345678a5a5a5a5", dvalid0, dout0);
      end
      step();
      checks++;
      if (dvalid0 !== 2'b00 || dout0 !== 64'h1234_5678_A5A5_A5A5) begin
         failures++;
         $display("FAIL basic_hold: dvalid=%b dout=%h want 00 12345678a5a5a5a5", dvalid0, dout0);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 4; i++) begin
         wen   = 2'b01;
         waddr = {4'd0, 4'(i)};
         din   = {32'h0, 32'(10 + i)};
         step();
      end
      wen = 2'b00;
      for (int j = 0; j < 8; j++) begin
         ren   = (j < 4) ? 2'b01 : 2'b00;
         raddr = {4'd0, 4'(j)};
         step();
         checks++;
         if (j >= 2 && j <= 5) begin
            if (dvalid0 !== 2'b01 || dout0[31:0] !== 32'(10 + j - 2)) begin
               failures++;
               $display("FAIL stream_%0d: dvalid=%b dout0=%0d want 01 %0d", j, dvalid0,
                        dout0[31:0], 10 + j - 2);
            end
         end else if (j > 5) begin
            if (dvalid0 !== 2'b00 || dout0[31:0] !== 32'd13) begin
               failures++;
               $display("FAIL stream_hold_%0d: dvalid=%b dout0=%0d want 00 13", j, dvalid0,
                        dout0[31:0]);
            end
         end else if (dvalid0 !== 2'b00) begin
            failures++;
            $display("FAIL stream_lead_%0d: dvalid=%b want 00", j, dvalid0);
         end
      end
      ren = 2'b00;
   endtask

   task automatic test_rdw();
      logic [63:0] d0, d1;
      logic [1:0]  v;
      wen   = 2'b01;
      waddr = {4'd0, 4'd5};
      din   = {32'h0, 32'd7};
      step();
      din   = {32'h0, 32'd9};
      ren   = 2'b01;
      raddr = {4'd0, 4'd5};
      step();
      wen = 2'b00;
      ren = 2'b00;
      step();
      step();
      checks++;
      if (dvalid0[0] !== 1'b1 || dout0[31:0] !== 32'd7) begin
         failures++;
         $display("FAIL rdw_old: dvalid=%b dout0=%0d want 1 7", dvalid0[0], dout0[31:0]);
      end
      checks++;
      if (dvalid1[0] !== 1'b1 || dout1[31:0] !== 32'd9) begin
         failures++;
         $display("FAIL rdw_new: dvalid=%b dout0=%0d want 1 9", dvalid1[0], dout1[31:0]);
      end
      read_pair(4'd5, d0, d1, v);
      checks++;
      if (v[0] !== 1'b1 || d0[31:0] !== 32'd9 || d1[31:0] !== 32'd9) begin
         failures++;
         $display("FAIL rdw_after: dout0=%0d dout1=%0d want 9 9", d0[31:0], d1[31:0]);
      end
   endtask

   task automatic test_clear();
      logic [63:0] d0, d1;
      logic [1:0]  v;
      int          busy_cnt;
      int          bad_dv;
      fill_all();
      // Write and clear request in the same idle cycle: the sweep must win.
      wen   = 2'b11;
      waddr = {4'd0, 4'd0};
      din   = {32'hFFFF_FFFF, 32'hEEEE_EEEE};
      clr   = 1'b1;
      step();
      busy_cnt = 0;
      bad_dv   = 0;
      for (int i = 0; i < 40; i++) begin
         if (dvalid0 !== 2'b00) bad_dv++;
         if (busy0 !== 1'b1) break;
         busy_cnt++;
         wen   = 2'b11;
         waddr = {4'd7, 4'd7};
         din   = {32'hDEAD_BEEF, 32'hCAFE_F00D};
         ren   = 2'b11;
         raddr = {4'd2, 4'd2};
         clr   = 1'b1;
         step();
      end
      wen = 2'b00;
      ren = 2'b00;
      clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (dvalid0 !== 2'b00 || busy0 !== 1'b0) bad_dv++;
      end
      checks++;
      if (busy_cnt != 16) begin
         failures++;
         $display("FAIL clear_busy_len: busy cycles=%0d want 16", busy_cnt);
      end
      checks++;
      if (bad_dv != 0) begin
         failures++;
         $display("FAIL clear_ignore: stray dvalid/busy samples=%0d want 0", bad_dv);
      end
      for (int i = 0; i < 16; i++) begin
         read_pair(4'(i), d0, d1, v);
         checks++;
         if (v !== 2'b11 || d0 !== 64'h0) begin
            failures++;
            $display("FAIL clear_word_%0d: dvalid=%b dout=%h want 11 0", i, v, d0);
         end
      end
   endtask

   task automatic test_clear_abort();
      logic [63:0] d0, d1, exp;
      logic [1:0]  v;
      fill_all();
      clr = 1'b1;
      step();
      clr = 1'b0;
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (busy0 !== 1'b0) begin
         failures++;
         $display("FAIL abort_busy: busy=%b want 0", busy0);
      end
      step();
      checks++;
      if (busy0 !== 1'b0) begin
         failures++;
         $display("FAIL abort_busy_stays: busy=%b want 0", busy0);
      end
      for (int i = 0; i < 16; i++) begin
         read_pair(4'(i), d0, d1, v);
         exp = (i < 6) ? 64'h0
                       : {32'hC000_0000 + 32'(i + 1), 32'hB000_0000 + 32'(i + 1)};
         checks++;
         if (v !== 2'b11 || d0 !== exp) begin
            failures++;
            $display("FAIL abort_word_%0d: dvalid=%b dout=%h want 11 %h", i, v, d0, exp);
         end
      end
   endtask

   task automatic test_reset_inflight();
      ren   = 2'b01;
      raddr = {4'd0, 4'd10};
      step();
      ren   = 2'b11;
      reset = 1'b1;
      step();
      reset = 1'b0;
      ren   = 2'b00;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dvalid0 !== 2'b00 || dout0 !== 64'h0 || dvalid1 !== 2'b00 || dout1 !== 64'h0) begin
            failures++;
            $display("FAIL inflight_%0d: dvalid=%b/%b dout=%h/%h want 00 and 0", i, dvalid0,
                     dvalid1, dout0, dout1);
         end
         step();
      end
   endtask

   initial begin
      reset = 1'b1;
      wen   = 2'b00;
      ren   = 2'b00;
      waddr = '0;
      raddr = '0;
      din   = '0;
      clr   = 1'b0;
      step();
      test_reset();
      test_basic();
      test_stream();
      test_rdw();
      test_clear();
      test_clear_abort();
      test_reset_inflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
